addr_ser_ft: RTL and testbench
==============================

# addr_ser_ft

Parametrised digit-serial unsigned adder with duplicated digit datapath, per-digit compare, bounded retry and uncorrectable-error flagging. It is the sequential, width-generic successor to the fixed 8-bit fault-resilient adders in the arithmetic library. Area is traded for latency: one DIGIT-wide slice is evaluated per cycle by two redundant copies. It sits behind a valid/ready handshake for use in multi-cycle datapaths.

## Interface
- WIDTH, 8: operand width. Must be a multiple of DIGIT, and WIDTH ≥ DIGIT.
- DIGIT, 2: bits processed per cycle. N = WIDTH/DIGIT digit steps.
- MAX_RETRY, 2: extra attempts per digit after a mismatch. Range 0..15.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH+1  a+b. The MSB is the carry-out.
- err  out  1  qualified by out_valid. At least one digit was committed without agreement.
- fault_cnt  out  8  detected mismatches since reset. Saturates at 255.
- inj  in  DIGIT+1  fault-injection mask. While in CALC, it is XORed into copy B's {carry, digit} result. Tie to 0 in mission mode.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: register a and b, clear carry, digit index k, retry count, sum register and err. Go to CALC.
- CALC, each cycle:
  - Copies A and B each compute {c, d} = a[k] + b[k] + carry, where a[k] and b[k] are DIGIT-bit slices and k=0 is the LSB.
  - Copy B's result is XORed with inj before the compare.
- Match: commit d to sum slice k, carry ← c, k ← k+1, retry count ← 0.
- Mismatch with retry count < MAX_RETRY: commit nothing, retry count +1, fault_cnt +1 (saturating).
- Mismatch with retry count = MAX_RETRY: commit copy A's result, set err, fault_cnt +1, advance k, retry count ← 0.
- Commit of digit N-1: sum[WIDTH] ← carry-out. Go to DONE.
- DONE:
  - out_valid = 1; sum and err are held stable.
  - in_ready = 0; in_valid is ignored.
  - On out_ready: go to IDLE.
- fault_cnt is never cleared except by rst.

## Timing
- Reset values, all forced asynchronously while rst is high:
  - state = IDLE; in_ready = 0 while rst is high, 1 from the first cycle after deassertion.
  - out_valid = 0, sum = 0, err = 0, fault_cnt = 0.
  - Internal k, carry and retry count = 0.
- Fault-free latency:
  - Operands are accepted at edge t.
  - out_valid rises after edge t+N.
  - Worst case is t+N·(1+MAX_RETRY).
- The earliest next accept is the edge after the out_valid && out_ready handshake. There is no overlap of operations.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready.
- Reset mid-CALC or mid-DONE aborts the operation. The partial result is discarded and never presented.
- inj is sampled every CALC cycle. Changing it mid-operation affects only the current digit attempt.

## Structure
- Package addr_ft_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the fault_cnt width constant (8);
  - a function returning N from WIDTH and DIGIT.
- Sub-module addr_digit_unit: combinational DIGIT-bit adder with cin, producing {cout, d}. It is instantiated twice, as copies A and B.
- Top level holds the FSM, operand/sum shift or index registers, the comparator, the retry counter and fault_cnt.
- A parameter legality check (WIDTH % DIGIT == 0) is elaborated at the top level.

## Test plan
1. Reset: assert rst for 3 cycles mid-idle → in_ready=0 during reset, out_valid=0, sum=0, err=0, fault_cnt=0; in_ready=1 on the first post-reset cycle.
2. WIDTH=8, DIGIT=2, inj=0, a=0xFF, b=0x01 → sum=0x100, err=0, out_valid after edge t+4, fault_cnt=0.
3. a=0xA5, b=0x5A, inj=3'b001 for the single cycle evaluating digit 1 → sum=0x0FF, err=0, latency 5, fault_cnt=1.
4. MAX_RETRY=2, inj=3'b100 held through the whole operation, a=0x3C, b=0x81 → sum=0x0BD (copy A), err=1, latency 12, fault_cnt=12.
5. Backpressure: hold out_ready=0 for 6 cycles in DONE while pulsing in_valid with new operands → sum, err and out_valid stay stable, in_ready=0, new operands are not captured; the next accept comes one cycle after out_ready=1.
6. Reset asserted during digit 2 of a=0xF0, b=0x0F → all outputs return to reset values immediately. A following a=0x01, b=0x01 yields sum=0x002, err=0.

Source files
------------

// File: rtl/addr_ft_pkg.sv
// Shared definitions for the fault-tolerant digit-serial adder.
//   state_t      : control FSM encoding (IDLE, CALC, DONE)
//   FAULT_CNT_W  : width of the saturating mismatch counter
//   num_digits() : digit steps per operation (WIDTH / DIGIT)
package addr_ft_pkg;

    localparam int unsigned FAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int unsigned num_digits(input int unsigned width,
                                               input int unsigned digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/addr_digit_unit.sv
// One DIGIT-wide slice adder with carry-in; purely combinational.
//   a, b  : digit operands
//   cin   : carry-in
//   res_c : {carry-out, digit sum}
module addr_digit_unit #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT:0]   res_c
);

    assign res_c = (DIGIT+1)'(a) + (DIGIT+1)'(b) + (DIGIT+1)'(cin);

endmodule

// File: rtl/addr_ser_ft.sv
// Digit-serial unsigned adder with two redundant digit copies, per-digit
// compare, bounded retry and uncorrectable-error flag.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b captured on accept)
//   out_valid/out_ready : result handshake (sum, err held while valid)
//   sum                 : a + b, MSB is carry-out
//   err                 : a digit was committed without copy agreement
//   fault_cnt           : saturating count of mismatches since reset
//   inj                 : XOR mask on copy B's {carry, digit} during CALC
module addr_ser_ft
    import addr_ft_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIGIT     = 2,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH:0]         sum,
    output logic                   err,
    output logic [FAULT_CNT_W-1:0] fault_cnt,
    input  logic [DIGIT:0]         inj
);

    localparam int unsigned N  = num_digits(WIDTH, DIGIT);
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned RW = 4;

    // Parameter legality, rejected at elaboration
    if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT || MAX_RETRY > 15) begin : g_bad_params
        $error("addr_ser_ft: illegal WIDTH/DIGIT/MAX_RETRY combination");
    end

    state_t                 state_q, state_n;
    logic [WIDTH-1:0]       a_q, a_n, b_q, b_n;
    logic                   carry_q, carry_n;
    logic [KW-1:0]          k_q, k_n;
    logic [RW-1:0]          retry_q, retry_n;
    logic [WIDTH:0]         sum_q, sum_n;
    logic                   err_q, err_n;
    logic [FAULT_CNT_W-1:0] fault_q, fault_n;
    logic                   in_ready_q, in_ready_n;
    logic                   out_valid_q, out_valid_n;

    logic [DIGIT-1:0]       a_dig, b_dig;
    logic [DIGIT:0]         res_a, res_b, res_b_f;
    logic                   match, last;

    // Select digit k of each operand
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (k_q == KW'(i)) begin
                a_dig = a_q[i*DIGIT +: DIGIT];
                b_dig = b_q[i*DIGIT +: DIGIT];
            end
        end
    end

    addr_digit_unit #(.DIGIT(DIGIT)) u_copy_a (
        .a     (a_dig),
        .b     (b_dig),
        .cin   (carry_q),
        .res_c (res_a)
    );

    addr_digit_unit #(.DIGIT(DIGIT)) u_copy_b (
        .a     (a_dig),
        .b     (b_dig),
        .cin   (carry_q),
        .res_c (res_b)
    );

    assign res_b_f = res_b ^ inj;
    assign match   = (res_a == res_b_f);
    assign last    = (k_q == KW'(N - 1));

    // Next-state and datapath update
    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        carry_n = carry_q;
        k_n     = k_q;
        retry_n = retry_q;
        sum_n   = sum_q;
        err_n   = err_q;
        fault_n = fault_q;

        case (state_q)
            S_IDLE: begin
                // in_ready_q gates accept so nothing is taken while it still reads 0
                if (in_valid && in_ready_q) begin
                    a_n     = a;
                    b_n     = b;
                    carry_n = 1'b0;
                    k_n     = '0;
                    retry_n = '0;
                    sum_n   = '0;
                    err_n   = 1'b0;
                    state_n = S_CALC;
                end
            end
            S_CALC: begin
                if (!match && fault_q != {FAULT_CNT_W{1'b1}}) begin
                    fault_n = fault_q + FAULT_CNT_W'(1);
                end
                if (match || retry_q == RW'(MAX_RETRY)) begin
                    // Commit copy A's result; out of retries means unverified
                    for (int i = 0; i < int'(N); i++) begin
                        if (k_q == KW'(i)) begin
                            sum_n[i*DIGIT +: DIGIT] = res_a[DIGIT-1:0];
                        end
                    end
                    carry_n = res_a[DIGIT];
                    retry_n = '0;
                    if (!match) begin
                        err_n = 1'b1;
                    end
                    if (last) begin
                        sum_n[WIDTH] = res_a[DIGIT];
                        k_n          = '0;
                        state_n      = S_DONE;
                    end else begin
                        k_n = k_q + KW'(1);
                    end
                end else begin
                    retry_n = retry_q + RW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        in_ready_n  = (state_n == S_IDLE);
        out_valid_n = (state_n == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            k_q         <= '0;
            retry_q     <= '0;
            sum_q       <= '0;
            err_q       <= 1'b0;
            fault_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            a_q         <= a_n;
            b_q         <= b_n;
            carry_q     <= carry_n;
            k_q         <= k_n;
            retry_q     <= retry_n;
            sum_q       <= sum_n;
            err_q       <= err_n;
            fault_q     <= fault_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign err       = err_q;
    assign fault_cnt = fault_q;

endmodule

// File: tb/tb_addr_ser_ft.sv
// Self-checking bench for addr_ser_ft (WIDTH=8, DIGIT=2, MAX_RETRY=2).
module tb_addr_ser_ft;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned DIGIT     = 2;
    localparam int unsigned MAX_RETRY = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH:0]   sum;
    logic             err;
    logic [7:0]       fault_cnt;
    logic [DIGIT:0]   inj = '0;

    addr_ser_ft #(.WIDTH(WIDTH), .DIGIT(DIGIT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .err       (err),
        .fault_cnt (fault_cnt),
        .inj       (inj)
    );

    always #5 clk = ~clk;

    // inj modes: 0 none, 1 = 3'b001 only while digit 1 is first evaluated,
    // 2 = 3'b100 held for the whole operation
    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        int         mode;
        logic [8:0] esum;
        logic       eerr;
        int         elat;
        int         efaults;
    } vec_t;

    typedef struct {
        logic [8:0] esum;
        logic       eerr;
        int         elat;
        int         efcnt;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   exp_faults = 0;
    exp_t sb[$];
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation, wait for its result, compare against the scoreboard,
    // optionally stall in DONE for 'hold' cycles while pulsing in_valid.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input int mode,
                          input logic [8:0] esum, input logic eerr, input int elat,
                          input int efaults, input int hold, input string tag);
        int   n;
        int   lat;
        exp_t e;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        exp_faults += efaults;
        e.esum  = esum;
        e.eerr  = eerr;
        e.elat  = elat;
        e.efcnt = exp_faults;
        sb.push_back(e);
        a = va;
        b = vb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            case (mode)
                1:       inj = (cyc == 2) ? 3'b001 : 3'b000;
                2:       inj = 3'b100;
                default: inj = 3'b000;
            endcase
            step();
            if (out_valid) begin
                lat = cyc;
                break;
            end
        end
        inj = '0;
        if (lat == 0) begin
            check({tag, "_timeout_out_valid"}, 32'(out_valid), 32'd1);
            void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard actual=empty required=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"},       32'(sum),       32'(e.esum));
            check({tag, "_err"},       32'(err),       32'(e.eerr));
            check({tag, "_latency"},   32'(lat),       32'(e.elat));
            check({tag, "_fault_cnt"}, 32'(fault_cnt), 32'(e.efcnt));
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = h[0] ? 1'b0 : 1'b1;
            a = 8'hFF;
            b = 8'hEE;
            step();
            check({tag, "_hold_stable"}, 32'({out_valid, in_ready, err, sum}),
                  32'({1'b1, 1'b0, eerr, esum}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_in_ready"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        vec_t       v;

        // Reset held for 3 cycles
        rst = 1'b1;
        step();
        step();
        step();
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_fault_cnt", 32'(fault_cnt), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors with hand-derived results
        tbl.push_back('{8'hFF, 8'h01, 0, 9'h100, 1'b0, 4, 0});
        tbl.push_back('{8'hA5, 8'h5A, 1, 9'h0FF, 1'b0, 5, 1});
        tbl.push_back('{8'h3C, 8'h81, 2, 9'h0BD, 1'b1, 12, 12});
        tbl.push_back('{8'h00, 8'h00, 0, 9'h000, 1'b0, 4, 0});
        tbl.push_back('{8'h55, 8'hAB, 0, 9'h100, 1'b0, 4, 0});
        tbl.push_back('{8'hFF, 8'hFF, 2, 9'h1FE, 1'b1, 12, 12});
        // Random fault-free vectors
        for (int r = 0; r < 5; r++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            tbl.push_back('{ra, rb, 0, {1'b0, ra} + {1'b0, rb}, 1'b0, 4, 0});
        end

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            run_op(v.va, v.vb, v.mode, v.esum, v.eerr, v.elat, v.efaults, 0,
                   $sformatf("vec%0d", i));
        end

        // Backpressure: 6 stalled cycles in DONE with in_valid pulses
        run_op(8'h12, 8'h34, 0, 9'h046, 1'b0, 4, 0, 6, "bp");
        // Operands presented during the stall must not have been captured
        run_op(8'h01, 8'h02, 0, 9'h003, 1'b0, 4, 0, 0, "bp_next");

        // Reset during digit 2 aborts the operation
        a = 8'hF0;
        b = 8'h0F;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("abort_no_early_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_in_ready",  32'(in_ready),  32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum",       32'(sum),       32'd0);
        check("abort_err",       32'(err),       32'd0);
        check("abort_fault_cnt", 32'(fault_cnt), 32'd0);
        exp_faults = 0;
        step();
        step();
        rst = 1'b0;
        step();
        check("abort_post_in_ready", 32'(in_ready), 32'd1);
        run_op(8'h01, 8'h01, 0, 9'h002, 1'b0, 4, 0, 0, "after_abort");

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
